// File: rtl/mem_access_seq.sv
// Byte-serial load/store sequencer: splits 8/16-bit requests into single-byte memory cycles
// and reassembles load results into a 16-bit response.
module mem_access_seq #(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_wide,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata
);

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_write;
    logic        r_wide;
    logic [7:0]  r_addr;
    logic [15:0] r_wdata;
    logic [7:0]  r_last_addr;
    logic [7:0]  r_last_wdata;
    logic [7:0]  r_lo;
    logic [15:0] r_resp_rdata;

    logic        w_accept;
    logic [7:0]  w_addr_next;
    logic [7:0]  w_byte0_addr;
    logic [7:0]  w_byte1_addr;

    assign w_accept    = req_valid && (r_state == IDLE);
    assign w_addr_next = r_addr + 8'd1;
    // BYTE0 always carries the low data byte, BYTE1 the high byte; only the address differs.
    assign w_byte0_addr = (BIG_ENDIAN && r_wide) ? w_addr_next : r_addr;
    assign w_byte1_addr = BIG_ENDIAN ? r_addr : w_addr_next;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (req_valid) w_next_state = BYTE0;
            BYTE0:   w_next_state = r_wide ? BYTE1 : DONE;
            BYTE1:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        mem_we     = 1'b0;
        resp_valid = 1'b0;
        mem_addr   = r_last_addr;
        mem_wdata  = r_last_wdata;
        unique case (r_state)
            IDLE: req_ready = 1'b1;
            BYTE0: begin
                mem_we    = r_write;
                mem_addr  = w_byte0_addr;
                mem_wdata = r_wdata[7:0];
            end
            BYTE1: begin
                mem_we    = r_write;
                mem_addr  = w_byte1_addr;
                mem_wdata = r_wdata[15:8];
            end
            DONE:    resp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_write      <= 1'b0;
            r_wide       <= 1'b0;
            r_addr       <= 8'h00;
            r_wdata      <= 16'h0000;
            r_last_addr  <= 8'h00;
            r_last_wdata <= 8'h00;
            r_lo         <= 8'h00;
            r_resp_rdata <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_wide  <= req_wide;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == BYTE0 || r_state == BYTE1) begin
                r_last_addr  <= mem_addr;
                r_last_wdata <= mem_wdata;
            end
            // The visible result only changes when a load completes.
            if (r_state == BYTE0 && !r_write) begin
                if (r_wide) begin
                    r_lo <= mem_rdata;
                end else begin
                    r_resp_rdata <= {8'h00, mem_rdata};
                end
            end
            if (r_state == BYTE1 && !r_write) begin
                r_resp_rdata <= {mem_rdata, r_lo};
            end
        end
    end

    assign resp_rdata = r_resp_rdata;

endmodule
